bram_stream_reader: RTL and testbench

Read-side controller for the simple dual-port block RAM. It takes a start command with a base address and a word count and drives the RAM read port (read enable, read address). It absorbs the RAM's one-cycle registered-address read latency and presents the words as a valid/ready stream with a last flag. It sits between the RAM and downstream packet or DMA logic, which may stall at any time.

---
 rtl/bram_stream_reader.sv | 140 ++++++++++++++
 tb/tb_bram_stream_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Read-side controller for a simple dual-port block RAM.
// Issues reads for a base/length command and turns the RAM's one-cycle
// registered-address read latency into a valid/ready stream with a last flag.
module bram_stream_reader #(
  parameter int unsigned A_WID = 14,
  parameter int unsigned D_WID = 32
) (
  input  logic             rdclk,
  input  logic             rst,
  input  logic             start,
  input  logic [A_WID-1:0] base_addr,
  input  logic [A_WID:0]   len,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [A_WID-1:0] rdaddr,
  input  logic [D_WID-1:0] rddata,
  output logic             m_valid,
  output logic [D_WID-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  // Largest transfer: the whole address space once.
  localparam logic [A_WID:0] LenMax = {1'b1, {A_WID{1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [A_WID:0]   remaining_q, remaining_d;
  logic [A_WID-1:0] addr_q, addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Two-entry output FIFO; inflight marks a read issued last cycle whose data
  // is on rddata now.
  logic [D_WID-1:0] fifo_data_q [2];
  logic [1:0]       fifo_last_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             inflight_q, inflight_last_q;

  logic             pop, push, accept, issue_last;
  logic [2:0]       occupancy;
  logic [A_WID:0]   len_sat;

  assign m_valid = (count_q != 2'd0);
  assign m_data  = fifo_data_q[rd_ptr_q];
  assign m_last  = m_valid && fifo_last_q[rd_ptr_q];
  assign busy    = busy_q;
  assign done    = done_q;
  assign rdaddr  = addr_q;

  // Read issue: only when the FIFO can absorb the word that will land.
  always_comb begin
    pop        = m_valid && m_ready;
    push       = inflight_q;
    occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en      = (state_q == StRun) && (remaining_q != '0) && (occupancy < 3'd2);
    issue_last = rd_en && (remaining_q == (A_WID+1)'(1));
    accept     = start && (state_q == StIdle);
    len_sat    = (len > LenMax) ? LenMax : len;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Command FSM next-state, address and remaining-word bookkeeping.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (len_sat != '0) begin
            state_d     = StRun;
            remaining_d = len_sat;
            addr_d      = base_addr;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (rd_en) begin
          remaining_d = remaining_q - (A_WID+1)'(1);
          addr_d      = addr_q + A_WID'(1);
          if (issue_last) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && m_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge rdclk) begin
    if (rst) begin
      state_q         <= StIdle;
      remaining_q     <= '0;
      addr_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      count_q         <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      fifo_last_q     <= 2'b00;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      addr_q          <= addr_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      count_q         <= count_d;
      inflight_q      <= rd_en;
      inflight_last_q <= issue_last;
      if (push) begin
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // FIFO payload; no reset needed since m_valid gates its use.
  always_ff @(posedge rdclk) begin
    if (push) fifo_data_q[wr_ptr_q] <= rddata;
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a registered-read RAM model.
module tb_bram_stream_reader;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done, rd_en;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] rddata;
  logic          m_valid, m_last, m_ready;
  logic [DW-1:0] m_data;

  bram_stream_reader #(.A_WID(AW), .D_WID(DW)) dut (
    .rdclk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .rd_en(rd_en), .rdaddr(rdaddr), .rddata(rddata),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM read port: registered address, data valid the cycle after rd_en.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (rd_en) rddata <= mem[rdaddr];

  // Downstream ready: fixed level or the 1,0,0,1 stall pattern.
  logic       bp_on = 1'b0;
  logic       ready_hold = 1'b1;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_idx = 0;
  always @(posedge clk) begin
    #1;
    if (bp_on) begin
      m_ready = bp_pat[bp_idx];
      bp_idx  = (bp_idx + 1) % 4;
    end else begin
      m_ready = ready_hold;
      bp_idx  = 0;
    end
  end

  // Stream / read-port observer.
  logic [DW-1:0] beat_data [$];
  logic          beat_last [$];
  int            beat_cyc [$];
  logic [AW-1:0] rd_addr_log [$];
  int            rd_cyc [$];
  int            done_cnt = 0, stall_bad = 0, gate_bad = 0, issued = 0, popped = 0;
  logic          stall = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;
  always @(negedge clk) begin
    if (rst) begin
      issued = 0;
      popped = 0;
      stall  = 1'b0;
    end else begin
      if (stall && !(m_valid && m_data == stall_data && m_last == stall_last)) stall_bad++;
      if (rd_en) begin
        if (issued - popped - ((m_valid && m_ready) ? 1 : 0) >= 2) gate_bad++;
        rd_addr_log.push_back(rdaddr);
        rd_cyc.push_back(cyc);
        issued++;
      end
      if (m_valid && m_ready) begin
        beat_data.push_back(m_data);
        beat_last.push_back(m_last);
        beat_cyc.push_back(cyc);
        popped++;
      end
      if (issued - popped > 2) gate_bad++;
      if (done) done_cnt++;
      stall      = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
    end
  end

  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  int t0;
  task automatic issue(input logic [AW-1:0] b, input logic [AW:0] l);
    start     = 1'b1;
    base_addr = b;
    len       = l;
    t0        = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag, output int dcyc);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
    dcyc = cyc - t0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int b0, r0, d0, sb0, gb0, dc, n, errs, nlast, idx;

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(32'hA000 + i);
    idle(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_rdaddr", rdaddr, 0);
    rst = 1'b0;
    idle(2);

    // Basic burst with exact cycle timing.
    b0 = beat_data.size(); r0 = rd_addr_log.size(); d0 = done_cnt;
    issue(14'h10, 15'd8);
    check("t1_busy", busy, 1);
    check("t1_rd_en", rd_en, 1);
    check("t1_rdaddr", rdaddr, 14'h10);
    wait_done(64, "t1", dc);
    check("t1_done_cyc", dc, 11);
    check("t1_busy_in_done", busy, 0);
    check("t1_nbeats", beat_data.size() - b0, 8);
    check("t1_nreads", rd_addr_log.size() - r0, 8);
    check("t1_rd_first", rd_cyc[r0] - t0, 1);
    check("t1_rd_lastc", rd_cyc[r0+7] - t0, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_data%0d", i), beat_data[b0+i], 32'hA010 + i);
      check($sformatf("t1_last%0d", i), beat_last[b0+i], (i == 7) ? 1 : 0);
      check($sformatf("t1_cyc%0d", i), beat_cyc[b0+i] - t0, 3 + i);
    end
    idle(3);
    check("t1_done_cnt", done_cnt - d0, 1);

    // Backpressure.
    bp_on = 1'b1;
    idle(1);
    b0 = beat_data.size(); d0 = done_cnt; sb0 = stall_bad; gb0 = gate_bad;
    issue(14'h10, 15'd8);
    wait_done(200, "t2", dc);
    bp_on = 1'b0;
    idle(3);
    check("t2_nbeats", beat_data.size() - b0, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_data%0d", i), beat_data[b0+i], 32'hA010 + i);
      check($sformatf("t2_last%0d", i), beat_last[b0+i], (i == 7) ? 1 : 0);
    end
    check("t2_done_cnt", done_cnt - d0, 1);
    check("t2_stall_stable", stall_bad - sb0, 0);
    check("t2_rd_gate", gate_bad - gb0, 0);

    // Address wrap.
    b0 = beat_data.size(); r0 = rd_addr_log.size();
    issue(14'h3FFE, 15'd4);
    wait_done(64, "t3", dc);
    check("t3_nreads", rd_addr_log.size() - r0, 4);
    check("t3_addr0", rd_addr_log[r0],   14'h3FFE);
    check("t3_addr1", rd_addr_log[r0+1], 14'h3FFF);
    check("t3_addr2", rd_addr_log[r0+2], 14'h0000);
    check("t3_addr3", rd_addr_log[r0+3], 14'h0001);
    check("t3_data0", beat_data[b0],   32'hDFFE);
    check("t3_data1", beat_data[b0+1], 32'hDFFF);
    check("t3_data2", beat_data[b0+2], 32'hA000);
    check("t3_data3", beat_data[b0+3], 32'hA001);
    check("t3_last3", beat_last[b0+3], 1);
    idle(2);

    // len == 0.
    b0 = beat_data.size(); r0 = rd_addr_log.size(); d0 = done_cnt;
    issue(14'h20, 15'd0);
    check("t4_len0_done", done, 1);
    check("t4_len0_busy", busy, 0);
    idle(4);
    check("t4_len0_beats", beat_data.size() - b0, 0);
    check("t4_len0_reads", rd_addr_log.size() - r0, 0);
    check("t4_len0_dcnt", done_cnt - d0, 1);

    // len == 1.
    b0 = beat_data.size();
    issue(14'h5, 15'd1);
    wait_done(32, "t4_len1", dc);
    check("t4_len1_done_cyc", dc, 4);
    check("t4_len1_beats", beat_data.size() - b0, 1);
    check("t4_len1_data", beat_data[b0], 32'hA005);
    check("t4_len1_last", beat_last[b0], 1);
    idle(2);

    // len above 2^A_WID saturates.
    b0 = beat_data.size();
    issue(14'h100, 15'd16389);
    wait_done(17000, "t4_big", dc);
    n = beat_data.size() - b0;
    check("t4_big_beats", n, 16384);
    errs = 0; nlast = 0;
    for (int i = 0; i < n; i++) begin
      idx = (32'h100 + i) & 32'h3FFF;
      if (beat_data[b0+i] !== DW'(32'hA000 + idx)) errs++;
      if (beat_last[b0+i]) nlast++;
    end
    check("t4_big_data_errs", errs, 0);
    check("t4_big_nlast", nlast, 1);
    check("t4_big_lastpos", beat_last[b0+n-1], 1);
    idle(2);

    // Start while busy is ignored; start in the done cycle is accepted.
    b0 = beat_data.size(); d0 = done_cnt;
    issue(14'h40, 15'd6);
    idle(1);
    start = 1'b1; base_addr = 14'h80; len = 15'd3;
    idle(1);
    start = 1'b0;
    wait_done(64, "t5a", dc);
    check("t5a_busy_in_done", busy, 0);
    check("t5a_nbeats", beat_data.size() - b0, 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t5a_data%0d", i), beat_data[b0+i], 32'hA040 + i);
    b0 = beat_data.size();
    issue(14'h200, 15'd2);
    wait_done(64, "t5b", dc);
    check("t5b_nbeats", beat_data.size() - b0, 2);
    check("t5b_first_cyc", beat_cyc[b0] - t0, 3);
    check("t5b_data0", beat_data[b0],   32'hA200);
    check("t5b_data1", beat_data[b0+1], 32'hA201);
    check("t5b_last0", beat_last[b0],   0);
    check("t5b_last1", beat_last[b0+1], 1);
    idle(3);
    check("t5_done_cnt", done_cnt - d0, 2);

    // Reset mid-command.
    b0 = beat_data.size(); d0 = done_cnt;
    issue(14'h10, 15'd8);
    n = 0;
    while (beat_data.size() - b0 < 3 && n < 32) begin
      idle(1);
      n++;
    end
    check("t6_three_beats", beat_data.size() - b0, 3);
    rst = 1'b1;
    idle(1);
    check("t6_m_valid", m_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_rd_en", rd_en, 0);
    rst = 1'b0;
    idle(5);
    check("t6_no_done", done_cnt - d0, 0);
    b0 = beat_data.size();
    issue(14'h300, 15'd4);
    wait_done(64, "t6b", dc);
    check("t6b_nbeats", beat_data.size() - b0, 4);
    check("t6b_first_cyc", beat_cyc[b0] - t0, 3);
    for (int i = 0; i < 4; i++)
      check($sformatf("t6b_data%0d", i), beat_data[b0+i], 32'hA300 + i);
    check("t6b_last3", beat_last[b0+3], 1);
    check("all_stall_stable", stall_bad, 0);
    check("all_rd_gate", gate_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
